// File: rtl/button_event.sv
// Turns a debounced button level into registered press / release / long-press / auto-repeat pulses
// and keeps a wrapping press counter. Define BUTTON_EVENT_REPEAT_EN to enable the auto-repeat pulse.
module button_event #(
    parameter int LONG_CNT   = 1_000_000,
    parameter int REPEAT_CNT = 250_000,
    parameter int CNT_W      = 21
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       long_hold,
    output logic       repeat_pulse,
    output logic [7:0] press_cnt,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESSED = 2'd1;
    localparam logic [1:0] HELD    = 2'd2;

    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Both terminal counts must fit the hold counter and be at least 2.
    if (LONG_CNT < 2 || REPEAT_CNT < 2 ||
        (LONG_CNT - 1) >= (1 << CNT_W) || (REPEAT_CNT - 1) >= (1 << CNT_W)) begin : g_param_check
        $error("button_event: LONG_CNT/REPEAT_CNT out of range for CNT_W");
    end

    logic [1:0]       state;
    logic             btn_q;
    logic [CNT_W-1:0] hold_cnt;
    logic             rise;

    // btn_q resets high so a button already held through reset never reads as a press.
    assign rise      = btn & ~btn_q;
    assign state_dbg = state;

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CNT - 1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= (state == HELD) && btn && (hold_cnt == REPEAT_TERM);
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            btn_q         <= 1'b1;
            hold_cnt      <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            long_hold     <= 1'b0;
            press_cnt     <= 8'd0;
        end else begin
            btn_q         <= btn;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;

            case (state)
                IDLE: begin
                    // A fall seen here only follows a press that was held through reset.
                    if (rise) begin
                        press_pulse <= 1'b1;
                        press_cnt   <= press_cnt + 8'd1;
                        hold_cnt    <= '0;
                        state       <= PRESSED;
                    end
                end

                PRESSED: begin
                    if (!btn) begin
                        release_pulse <= 1'b1;
                        hold_cnt      <= '0;
                        state         <= IDLE;
                    end else if (hold_cnt == LONG_TERM) begin
                        long_pulse <= 1'b1;
                        long_hold  <= 1'b1;
                        hold_cnt   <= '0;
                        state      <= HELD;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                    end
                end

                HELD: begin
                    if (!btn) begin
                        release_pulse <= 1'b1;
                        long_hold     <= 1'b0;
                        hold_cnt      <= '0;
                        state         <= IDLE;
                    end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
                        // Free-running repeat period; the wrap itself is the repeat event.
                        if (hold_cnt == REPEAT_TERM) begin
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + CNT_ONE;
                        end
`else
                        hold_cnt <= '0;
`endif
                    end
                end

                default: begin
                    state     <= IDLE;
                    hold_cnt  <= '0;
                    long_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event with LONG_CNT=8, REPEAT_CNT=4, CNT_W=4.
// Hand-written vector table first, then a behavioural model feeds the expected queue.
module tb_button_event;

    localparam int LONG   = 8;
    localparam int REPEAT = 4;
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       btn;
    logic       press_pulse, release_pulse, long_pulse, long_hold, repeat_pulse;
    logic [7:0] press_cnt;
    logic [1:0] state_dbg;

    button_event #(.LONG_CNT(LONG), .REPEAT_CNT(REPEAT), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .btn(btn),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .long_hold(long_hold), .repeat_pulse(repeat_pulse),
        .press_cnt(press_cnt), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // packed result: {state[1:0], press, release, long, long_hold, repeat, press_cnt[7:0]}
    localparam int W = 15;
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int t_press, t_long;
    int rep_t[$];
    int n_press = 0, n_rel = 0, n_long = 0;

    typedef struct {
        logic         rst_n;
        logic         btn;
        int           reps;
        logic [W-1:0] exp;
    } vec_t;
    vec_t tbl[7];

    // behavioural model state
    bit         m_prev, m_in, m_lh;
    int         m_run;
    logic [7:0] m_cnt;

    function automatic logic [W-1:0] mk(input logic [1:0] st, input logic p, input logic rl,
                                        input logic lg, input logic lh, input logic rp,
                                        input logic [7:0] cnt);
        return {st, p, rl, lg, lh, rp, cnt};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input logic r, input logic b, output logic [W-1:0] e);
        logic p = 1'b0, rl = 1'b0, lg = 1'b0, rp = 1'b0;
        logic [1:0] st;
        if (!r) begin
            m_prev = 1'b1; m_in = 1'b0; m_lh = 1'b0; m_run = 0; m_cnt = 8'd0;
        end else begin
            if (m_in && !b) begin
                rl = 1'b1; m_in = 1'b0; m_lh = 1'b0;
            end else if (m_in) begin
                m_run++;
                if (m_run == LONG) begin
                    lg = 1'b1; m_lh = 1'b1;
                end else if (REP_EN && m_run > LONG && ((m_run - LONG) % REPEAT) == 0) begin
                    rp = 1'b1;
                end
            end else if (b && !m_prev) begin
                p = 1'b1; m_cnt++; m_in = 1'b1; m_run = 0;
            end
            m_prev = b;
        end
        st = !m_in ? 2'd0 : (m_lh ? 2'd2 : 2'd1);
        e = mk(st, p, rl, lg, m_lh, rp, m_cnt);
    endtask

    // driver: inputs on the falling edge, outputs sampled 1 time unit after the rising edge
    task automatic drive(input logic r, input logic b, input logic [W-1:0] e, input string name);
        logic [W-1:0] act, got;
        @(negedge clk);
        reset_n = r;
        btn     = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        act = {state_dbg, press_pulse, release_pulse, long_pulse, long_hold, repeat_pulse, press_cnt};
        got = exp_q.pop_front();
        checks++;
        if (act !== got) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, got, cyc);
        end
        check("one_hot_pulses",
              ($countones({press_pulse, release_pulse, long_pulse, repeat_pulse}) <= 1) ? 1 : 0, 1);
        if (press_pulse)   begin t_press = cyc; n_press++; end
        if (long_pulse)    begin t_long = cyc;  n_long++;  end
        if (release_pulse) n_rel++;
        if (repeat_pulse)  rep_t.push_back(cyc);
    endtask

    task automatic mdrive(input logic r, input logic b, input string name);
        logic [W-1:0] e;
        model_step(r, b, e);
        drive(r, b, e, name);
    endtask

    initial begin
        logic [W-1:0] dummy;
        int n0, r0;
        reset_n = 1'b0;
        btn     = 1'b1;

        tbl[0] = '{1'b0, 1'b1, 4,  mk(2'd0, 0, 0, 0, 0, 0, 8'd0)};
        tbl[1] = '{1'b1, 1'b1, 20, mk(2'd0, 0, 0, 0, 0, 0, 8'd0)};
        tbl[2] = '{1'b1, 1'b0, 2,  mk(2'd0, 0, 0, 0, 0, 0, 8'd0)};
        tbl[3] = '{1'b1, 1'b1, 1,  mk(2'd1, 1, 0, 0, 0, 0, 8'd1)};
        tbl[4] = '{1'b1, 1'b1, 2,  mk(2'd1, 0, 0, 0, 0, 0, 8'd1)};
        tbl[5] = '{1'b1, 1'b0, 1,  mk(2'd0, 0, 1, 0, 0, 0, 8'd1)};
        tbl[6] = '{1'b1, 1'b0, 2,  mk(2'd0, 0, 0, 0, 0, 0, 8'd1)};

        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < tbl[i].reps; j++) begin
                model_step(tbl[i].rst_n, tbl[i].btn, dummy);
                drive(tbl[i].rst_n, tbl[i].btn, tbl[i].exp, $sformatf("tbl%0d", i));
            end
        end

        // long hold: press plus 19 more high cycles, then release
        rep_t.delete();
        for (int i = 0; i < 20; i++) mdrive(1'b1, 1'b1, "hold20");
        mdrive(1'b1, 1'b0, "hold20_rel");
        check("long_latency", t_long - t_press, LONG);
        check("repeat_count", rep_t.size(), REP_EN ? 2 : 0);
        for (int i = 0; i < rep_t.size(); i++)
            check("repeat_offset", rep_t[i] - t_long, REPEAT * (i + 1));
        check("hold20_release", release_pulse, 1);
        check("hold20_long_hold_low", long_hold, 0);

        // release on the terminal hold count: release wins over long
        mdrive(1'b1, 1'b0, "idle");
        n0 = n_long;
        for (int i = 0; i < LONG; i++) mdrive(1'b1, 1'b1, "term_hold");
        mdrive(1'b1, 1'b0, "term_rel");
        check("term_release", release_pulse, 1);
        check("term_no_long", n_long - n0, 0);

        // reset in HELD: everything clears, no release for the aborted press
        mdrive(1'b1, 1'b0, "idle");
        for (int i = 0; i < LONG + 3; i++) mdrive(1'b1, 1'b1, "held");
        check("in_held", state_dbg, 2);
        r0 = n_rel;
        mdrive(1'b0, 1'b1, "held_reset");
        check("reset_outputs",
              {press_pulse, release_pulse, long_pulse, long_hold, repeat_pulse, press_cnt}, 0);
        for (int i = 0; i < 3; i++) mdrive(1'b1, 1'b1, "post_reset_high");
        mdrive(1'b1, 1'b0, "post_reset_low");
        check("no_release_after_reset", n_rel - r0, 0);

        // 256 short presses wrap the counter
        n0 = n_press;
        for (int i = 0; i < 256; i++) begin
            mdrive(1'b1, 1'b1, "wrap_press");
            mdrive(1'b1, 1'b0, "wrap_rel");
        end
        check("wrap_presses", n_press - n0, 256);
        check("wrap_cnt", press_cnt, 0);

        // random button runs with occasional reset
        for (int k = 0; k < 40; k++) begin
            logic b;
            int len;
            b   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            for (int j = 0; j < len; j++) mdrive(1'b1, b, "random");
            if ($urandom_range(0, 9) == 0) mdrive(1'b0, 1'($urandom_range(0, 1)), "random_rst");
        end

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
